// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I memory arbiter: data width, FSM state encoding and transaction owner.
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/rv32i_mem_arbiter.sv
// Shares one synchronous memory port between fetch and load/store; gnt in IDLE/RESP, rvalid MEM_LAT+2 cycles later.
// One transaction in flight, so requesters simply hold their request until gnt; LS wins unless fetch is starved.
module rv32i_mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int AW         = 10,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [3:0]      ls_be,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  state_e          state_q;
  owner_e          owner_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [LW-1:0]   lat_q;
  logic [SW-1:0]   starve_q, starve_d;
  logic            mem_en_q, if_rvalid_q, ls_rvalid_q;
  logic [XLEN-1:0] if_rdata_q, ls_rdata_q;

  logic arb_en, starved, if_win, ls_win;
  logic unused_addr_bits;

  // Gated by rst so no grant escapes while the block is held in reset.
  assign arb_en  = rst && ((state_q == IDLE) || (state_q == RESP));
  assign starved = (STARVE_LIM > 0) && (starve_q == STARVE_MAX);
  assign if_win  = arb_en && if_req && (!ls_req || starved);
  assign ls_win  = arb_en && ls_req && !if_win;

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_win) begin
      starve_d = '0;
    end else if (ls_win && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        IDLE, RESP: begin
          if (if_win || ls_win) begin
            owner_q  <= if_win ? OWN_IF : OWN_LS;
            we_q     <= ls_win && ls_we;
            be_q     <= if_win ? 4'hF : ls_be;
            addr_q   <= if_win ? if_addr[AW+1:2] : ls_addr[AW+1:2];
            wdata_q  <= if_win ? '0 : ls_wdata;
            mem_en_q <= 1'b1;
            state_q  <= CMD;
          end else begin
            state_q <= IDLE;
          end
        end
        CMD: begin
          lat_q   <= LAT_LOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_q == LW'(1)) begin
            state_q <= RESP;
            if (owner_q == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata;
            end else begin
              // Stores complete with rvalid but leave the load data register untouched.
              ls_rvalid_q <= 1'b1;
              if (!we_q) ls_rdata_q <= mem_rdata;
            end
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

  assign unused_addr_bits = ^{if_addr[XLEN-1:AW+2], if_addr[1:0], ls_addr[XLEN-1:AW+2], ls_addr[1:0]};

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Three arbiter instances (MEM_LAT/STARVE_LIM = 1/4, 3/0, 2/4), each with its own word memory model.
module tb_rv32i_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req [3];
  logic [31:0] if_addr [3];
  logic        if_gnt [3], if_rvalid [3];
  logic [31:0] if_rdata [3];
  logic        ls_req [3], ls_we [3];
  logic [3:0]  ls_be [3];
  logic [31:0] ls_addr [3], ls_wdata [3];
  logic        ls_gnt [3], ls_rvalid [3];
  logic [31:0] ls_rdata [3];
  logic        mem_en [3], mem_we [3];
  logic [3:0]  mem_be [3];
  logic [9:0]  mem_addr [3];
  logic [31:0] mem_wdata [3], mem_rdata [3];
  logic        busy [3];

  logic        mem_clr, pre_vld;
  logic [9:0]  pre_addr;
  logic [31:0] pre_dat;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    localparam int LIM = (g == 1) ? 0 : 4;
    logic [31:0] mem  [0:1023];
    logic [31:0] pipe [0:3];

    rv32i_mem_arbiter #(.AW(10), .MEM_LAT(LAT), .STARVE_LIM(LIM)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_be(ls_be[g]), .ls_addr(ls_addr[g]),
      .ls_wdata(ls_wdata[g]), .ls_gnt(ls_gnt[g]), .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    // Read data is only valid in the exact cycle MEM_LAT after mem_en; poison otherwise.
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      end else if (pre_vld) begin
        mem[pre_addr] <= pre_dat;
      end else if (mem_en[g] && mem_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      end
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hBAD0_BAD0;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] ctl(input int d);
    return {if_gnt[d], ls_gnt[d], if_rvalid[d], ls_rvalid[d], mem_en[d], mem_we[d],
            mem_be[d], mem_addr[d], busy[d]};
  endfunction

  task automatic wait_idle(input int d, input string nm);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy[d]) break;
    end
    chk(nm, 64'(busy[d]), 64'd0);
    step();
  endtask

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [9:0]  exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_ls_rd;
  } vec_t;

  vec_t vt [8];

  initial begin
    int cnt, ng, nr, both, dly;
    int gc [3];
    int rc [3];

    vt[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,          10'd4, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vt[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0008, 32'h1234_5678,  10'd2, 4'h3, 32'hDEAD_BEEF, 32'h0};
    vt[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'h0,          10'd2, 4'hF, 32'hDEAD_BEEF, 32'h0000_5678};
    vt[3] = '{1'b1, 1'b1, 4'hC, 32'h0000_0008, 32'hAABB_CCDD,  10'd2, 4'hC, 32'hDEAD_BEEF, 32'h0000_5678};
    vt[4] = '{1'b0, 1'b0, 4'h0, 32'h0000_0008, 32'h0,          10'd2, 4'hF, 32'hAABB_5678, 32'h0000_5678};
    vt[5] = '{1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF,  10'd4, 4'h0, 32'hAABB_5678, 32'h0000_5678};
    vt[6] = '{1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0,          10'd4, 4'hF, 32'hAABB_5678, 32'hDEAD_BEEF};
    vt[7] = '{1'b0, 1'b0, 4'h0, 32'hABCD_E010, 32'h0,          10'd4, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    rst = 1'b0;
    mem_clr = 1'b0; pre_vld = 1'b0; pre_addr = '0; pre_dat = '0;
    for (int d = 0; d < 3; d++) begin
      if_req[d] = 1'b0; if_addr[d] = '0; ls_req[d] = 1'b0; ls_we[d] = 1'b0;
      ls_be[d] = '0; ls_addr[d] = '0; ls_wdata[d] = '0;
    end

    // Reset state of every instance.
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ctl%0d", d), 64'(ctl(d)), 64'd0);
      chk($sformatf("rst_ifrd%0d", d), 64'(if_rdata[d]), 64'd0);
      chk($sformatf("rst_lsrd%0d", d), 64'(ls_rdata[d]), 64'd0);
      chk($sformatf("rst_wdat%0d", d), 64'(mem_wdata[d]), 64'd0);
    end

    step(); mem_clr = 1'b1;
    step(); mem_clr = 1'b0; pre_vld = 1'b1; pre_addr = 10'd4; pre_dat = 32'hDEAD_BEEF;
    step(); pre_vld = 1'b0; rst = 1'b1;
    step();

    // Reset asserted mid-WAIT (MEM_LAT=3) drops the fetch.
    if_addr[1] = 32'h10; if_req[1] = 1'b1;
    @(negedge clk); chk("t1_gnt", 64'(if_gnt[1]), 64'd1);
    step(); if_req[1] = 1'b0;
    step();
    step();
    #2; if_req[1] = 1'b1; rst = 1'b0;
    #1;
    chk("t1_rst_ctl", 64'(ctl(1)), 64'd0);
    chk("t1_rst_ifrd", 64'(if_rdata[1]), 64'd0);
    step(); if_req[1] = 1'b0; rst = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if_rvalid[1] || ls_rvalid[1]) cnt++;
    end
    chk("t1_no_rvalid", 64'(cnt), 64'd0);
    chk("t1_busy", 64'(busy[1]), 64'd0);
    step();

    // Single transactions on instance 0 (MEM_LAT=1).
    for (int i = 0; i < 8; i++) begin
      if (vt[i].is_ls) begin
        ls_req[0] = 1'b1; ls_we[0] = vt[i].we; ls_be[0] = vt[i].be;
        ls_addr[0] = vt[i].addr; ls_wdata[0] = vt[i].wdata;
      end else begin
        if_req[0] = 1'b1; if_addr[0] = vt[i].addr;
      end
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 64'({if_gnt[0], ls_gnt[0], busy[0]}), vt[i].is_ls ? 64'b010 : 64'b100);
      step();
      if_req[0] = 1'b0; ls_req[0] = 1'b0; if_addr[0] = '0;
      ls_we[0] = 1'b0; ls_be[0] = 4'h0; ls_addr[0] = '0; ls_wdata[0] = 32'h5555_5555;
      @(negedge clk);
      chk($sformatf("v%0d_cmd", i), 64'({mem_en[0], mem_we[0], mem_be[0], mem_addr[0]}),
          64'({1'b1, vt[i].we, vt[i].exp_be, vt[i].exp_maddr}));
      if (vt[i].we) chk($sformatf("v%0d_wdata", i), 64'(mem_wdata[0]), 64'(vt[i].wdata));
      step();
      @(negedge clk);
      chk($sformatf("v%0d_wait", i), 64'({mem_en[0], if_rvalid[0], ls_rvalid[0], busy[0]}), 64'b0001);
      step();
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), 64'({if_rvalid[0], ls_rvalid[0]}), vt[i].is_ls ? 64'b01 : 64'b10);
      chk($sformatf("v%0d_ifrd", i), 64'(if_rdata[0]), 64'(vt[i].exp_if_rd));
      chk($sformatf("v%0d_lsrd", i), 64'(ls_rdata[0]), 64'(vt[i].exp_ls_rd));
      step();
    end

    // Both requesting with STARVE_LIM=4: LS x4 then IF, repeating.
    if_addr[0] = 32'h10; ls_addr[0] = 32'h8; ls_we[0] = 1'b0; ls_be[0] = 4'hF;
    if_req[0] = 1'b1; ls_req[0] = 1'b1;
    ng = 0; both = 0;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      @(negedge clk);
      if ((if_gnt[0] && ls_gnt[0]) || (if_rvalid[0] && ls_rvalid[0])) both++;
      if (if_gnt[0] || ls_gnt[0]) begin
        chk($sformatf("t4_grant%0d_is_if", ng), 64'(if_gnt[0]), 64'((ng % 5) == 4));
        ng++;
      end
    end
    chk("t4_grants", 64'(ng), 64'd10);
    chk("t4_simultaneous", 64'(both), 64'd0);
    step(); if_req[0] = 1'b0; ls_req[0] = 1'b0;
    wait_idle(0, "t4_idle");

    // STARVE_LIM=0: LS always wins; IF waits until ls_req drops, then wins in RESP.
    if_addr[1] = 32'h10; ls_addr[1] = 32'h8; ls_we[1] = 1'b0; ls_be[1] = 4'hF;
    if_req[1] = 1'b1; ls_req[1] = 1'b1;
    ng = 0;
    for (int c = 0; c < 200 && ng < 6; c++) begin
      @(negedge clk);
      if (if_gnt[1] || ls_gnt[1]) begin
        chk($sformatf("t5_grant%0d", ng), 64'({if_gnt[1], ls_gnt[1]}), 64'b01);
        ng++;
      end
    end
    chk("t5_ls_grants", 64'(ng), 64'd6);
    step(); ls_req[1] = 1'b0;
    dly = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if_gnt[1]) begin
        dly = c;
        break;
      end
    end
    chk("t5_if_gnt_delay", 64'(dly), 64'd5);
    step(); if_req[1] = 1'b0;
    wait_idle(1, "t5_idle");

    // Back-to-back loads, MEM_LAT=2: 4-cycle grant spacing, regrant alongside rvalid.
    gc = '{0, 0, 0}; rc = '{0, 0, 0};
    ls_addr[2] = 32'h10; ls_we[2] = 1'b0; ls_be[2] = 4'hF; ls_req[2] = 1'b1;
    ng = 0; nr = 0;
    for (int c = 0; c < 100 && ng < 3; c++) begin
      @(negedge clk);
      if (ls_rvalid[2] && nr < 3) begin
        if (nr == 0) chk("t6_rdata", 64'(ls_rdata[2]), 64'hDEAD_BEEF);
        rc[nr] = c; nr++;
      end
      if (ls_gnt[2]) begin
        gc[ng] = c; ng++;
      end
    end
    chk("t6_grants", 64'(ng), 64'd3);
    chk("t6_space01", 64'(gc[1] - gc[0]), 64'd4);
    chk("t6_space12", 64'(gc[2] - gc[1]), 64'd4);
    chk("t6_rvalid_vs_gnt", 64'(rc[0]), 64'(gc[1]));
    step(); ls_req[2] = 1'b0;
    wait_idle(2, "t6_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
